// File: rtl/flash_cmd_sched.sv
`default_nettype none
// ============================================================================
//  Module      : flash_cmd_sched
//  Description : Erase/status command sequencer for an SPI NOR flash
//                (M25P16-class). It issues WREN ahead of erase commands, sends
//                the command (and sector address), then polls RDSR until WIP
//                clears or the poll byte budget runs out.
//  Revision    : 1.0 - initial release
// ============================================================================
module flash_cmd_sched #(
    parameter int SCK_DIV  = 2,     // sys_clk cycles per sck half-period
    parameter int CS_GAP   = 4,     // cs_n high cycles between transactions
    parameter int POLL_MAX = 1024   // status bytes per poll before timeout
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [23:0] req_addr,
    input  logic        miso,
    output logic        sck,
    output logic        cs_n,
    output logic        mosi,
    output logic        busy,
    output logic        done,
    output logic [7:0]  status,
    output logic        timeout
);

    localparam int TMR_MAX = (SCK_DIV > CS_GAP) ? SCK_DIV : CS_GAP;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int PCNT_W  = $clog2(POLL_MAX + 1);

    localparam logic [TMR_W-1:0]  C_DIV_LAST  = TMR_W'(SCK_DIV - 1);
    localparam logic [TMR_W-1:0]  C_GAP_LAST  = TMR_W'(CS_GAP - 1);
    localparam logic [PCNT_W-1:0] C_POLL_LAST = PCNT_W'(POLL_MAX - 1);

    localparam logic [7:0] C_OP_WREN = 8'h06;
    localparam logic [7:0] C_OP_RDSR = 8'h05;
    localparam logic [7:0] C_OP_BE   = 8'hC7;
    localparam logic [7:0] C_OP_SE   = 8'hD8;

    localparam logic [1:0] C_REQ_BE   = 2'd0;
    localparam logic [1:0] C_REQ_SE   = 2'd1;
    localparam logic [1:0] C_REQ_RDSR = 2'd2;
    localparam logic [1:0] C_REQ_WREN = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WREN = 3'd1,
        S_GAP1 = 3'd2,
        S_CMD  = 3'd3,
        S_GAP2 = 3'd4,
        S_POLL = 3'd5,
        S_DONE = 3'd6
    } state_t;

    // Position inside an SPI transaction: sck low half, sck high half, or
    // the trailing low period before cs_n is released.
    typedef enum logic [1:0] {
        PH_LOW  = 2'd0,
        PH_HIGH = 2'd1,
        PH_TAIL = 2'd2
    } phase_t;

    state_t              state_q,   state_d;
    phase_t              phase_q,   phase_d;
    logic [TMR_W-1:0]    tmr_q,     tmr_d;
    logic [5:0]          bit_cnt_q, bit_cnt_d;
    logic [31:0]         sh_q,      sh_d;
    logic [7:0]          rx_q,      rx_d;
    logic                rd_q,      rd_d;
    logic [PCNT_W-1:0]   pcnt_q,    pcnt_d;
    logic [1:0]          op_q,      op_d;
    logic [23:0]         addr_q,    addr_d;
    logic                sck_q,     sck_d;
    logic                cs_n_q,    cs_n_d;
    logic                mosi_q,    mosi_d;
    logic [7:0]          status_q,  status_d;
    logic                timeout_q, timeout_d;

    logic                w_start;
    logic [31:0]         w_start_data;
    logic [5:0]          w_start_bits;

    // Next-state, bit engine and poll decisions; a transaction is opened by
    // raising w_start with left-aligned data and a bit count.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        tmr_d        = tmr_q;
        bit_cnt_d    = bit_cnt_q;
        sh_d         = sh_q;
        rx_d         = rx_q;
        rd_d         = rd_q;
        pcnt_d       = pcnt_q;
        op_d         = op_q;
        addr_d       = addr_q;
        sck_d        = sck_q;
        cs_n_d       = cs_n_q;
        mosi_d       = mosi_q;
        status_d     = status_q;
        timeout_d    = timeout_q;
        w_start      = 1'b0;
        w_start_data = 32'h0;
        w_start_bits = 6'd8;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d      = req_op;
                    addr_d    = req_addr;
                    timeout_d = 1'b0;
                    w_start   = 1'b1;
                    if (req_op == C_REQ_RDSR) begin
                        state_d      = S_POLL;
                        w_start_data = {C_OP_RDSR, 24'h0};
                    end else begin
                        state_d      = S_WREN;
                        w_start_data = {C_OP_WREN, 24'h0};
                    end
                end
            end

            S_GAP1: begin
                if (tmr_q == C_GAP_LAST) begin
                    state_d = S_CMD;
                    w_start = 1'b1;
                    if (op_q == C_REQ_SE) begin
                        w_start_data = {C_OP_SE, addr_q};
                        w_start_bits = 6'd32;
                    end else begin
                        w_start_data = {C_OP_BE, 24'h0};
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end

            S_GAP2: begin
                if (tmr_q == C_GAP_LAST) begin
                    state_d      = S_POLL;
                    w_start      = 1'b1;
                    w_start_data = {C_OP_RDSR, 24'h0};
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end

            S_WREN, S_CMD, S_POLL: begin
                case (phase_q)
                    PH_LOW: begin
                        if (tmr_q == C_DIV_LAST) begin
                            sck_d   = 1'b1;
                            tmr_d   = '0;
                            phase_d = PH_HIGH;
                            rx_d    = {rx_q[6:0], miso};
                        end else begin
                            tmr_d = tmr_q + TMR_W'(1);
                        end
                    end
                    PH_HIGH: begin
                        if (tmr_q == C_DIV_LAST) begin
                            sck_d = 1'b0;
                            tmr_d = '0;
                            sh_d  = sh_q << 1;
                            if (bit_cnt_q != 6'd1) begin
                                bit_cnt_d = bit_cnt_q - 6'd1;
                                phase_d   = PH_LOW;
                                mosi_d    = sh_q[30];
                            end else if (state_q == S_POLL && !rd_q) begin
                                // RDSR opcode sent; status bytes follow with mosi low
                                rd_d      = 1'b1;
                                bit_cnt_d = 6'd8;
                                phase_d   = PH_LOW;
                                mosi_d    = 1'b0;
                            end else if (state_q == S_POLL) begin
                                status_d = rx_q;
                                pcnt_d   = pcnt_q + PCNT_W'(1);
                                mosi_d   = 1'b0;
                                if (op_q == C_REQ_RDSR || !rx_q[0]) begin
                                    phase_d = PH_TAIL;
                                end else if (pcnt_q == C_POLL_LAST) begin
                                    timeout_d = 1'b1;
                                    phase_d   = PH_TAIL;
                                end else begin
                                    bit_cnt_d = 6'd8;
                                    phase_d   = PH_LOW;
                                end
                            end else begin
                                phase_d = PH_TAIL;
                                mosi_d  = 1'b0;
                            end
                        end else begin
                            tmr_d = tmr_q + TMR_W'(1);
                        end
                    end
                    PH_TAIL: begin
                        if (tmr_q == C_DIV_LAST) begin
                            cs_n_d = 1'b1;
                            tmr_d  = '0;
                            case (state_q)
                                S_WREN:  state_d = (op_q == C_REQ_WREN) ? S_DONE : S_GAP1;
                                S_CMD:   state_d = S_GAP2;
                                default: state_d = S_DONE;
                            endcase
                        end else begin
                            tmr_d = tmr_q + TMR_W'(1);
                        end
                    end
                    default: begin
                        phase_d = PH_LOW;
                    end
                endcase
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_start) begin
            cs_n_d    = 1'b0;
            sck_d     = 1'b0;
            sh_d      = w_start_data;
            mosi_d    = w_start_data[31];
            bit_cnt_d = w_start_bits;
            phase_d   = PH_LOW;
            tmr_d     = '0;
            rd_d      = 1'b0;
            pcnt_d    = '0;
        end
    end

    // State and output registers; reset forces cs_n high immediately.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= S_IDLE;
            phase_q   <= PH_LOW;
            tmr_q     <= '0;
            bit_cnt_q <= 6'd0;
            sh_q      <= 32'h0;
            rx_q      <= 8'h0;
            rd_q      <= 1'b0;
            pcnt_q    <= '0;
            op_q      <= 2'd0;
            addr_q    <= 24'h0;
            sck_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            status_q  <= 8'h0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            tmr_q     <= tmr_d;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            rx_q      <= rx_d;
            rd_q      <= rd_d;
            pcnt_q    <= pcnt_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            sck_q     <= sck_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
            status_q  <= status_d;
            timeout_q <= timeout_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign sck       = sck_q;
    assign cs_n      = cs_n_q;
    assign mosi      = mosi_q;
    assign status    = status_q;
    assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_flash_cmd_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flash_cmd_sched
//  Description : Directed vector bench for flash_cmd_sched with an SPI
//                transaction monitor and a simple status-register flash model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_cmd_sched;

    localparam int SCK_DIV  = 2;
    localparam int CS_GAP   = 4;
    localparam int POLL_MAX = 8;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op    = 2'd0;
    logic [23:0] req_addr  = 24'h0;
    logic        miso;
    logic        req_ready;
    logic        sck;
    logic        cs_n;
    logic        mosi;
    logic        busy;
    logic        done;
    logic [7:0]  status;
    logic        timeout;

    flash_cmd_sched #(
        .SCK_DIV  (SCK_DIV),
        .CS_GAP   (CS_GAP),
        .POLL_MAX (POLL_MAX)
    ) u_dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .miso      (miso),
        .sck       (sck),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .busy      (busy),
        .done      (done),
        .status    (status),
        .timeout   (timeout)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Flash model: read byte r of a poll returns wip_val while r < wip_cnt,
    // fin_val afterwards.
    int         wip_cnt = 0;
    logic [7:0] wip_val = 8'h00;
    logic [7:0] fin_val = 8'h00;

    // Transaction monitor results
    int          fr_nbits[$];
    logic [31:0] fr_w32[$];
    int          fr_low[$];
    int          fr_extra[$];
    int          gaps[$];
    int          done_cnt = 0;
    int          viol_cnt = 0;

    logic        prev_cs  = 1'b1;
    logic        prev_sck = 1'b0;
    int          m_nbits  = 0;
    int          m_low    = 0;
    int          m_extra  = 0;
    int          m_gap    = 0;
    logic [31:0] m_w32    = 32'h0;
    bit          have_frame = 1'b0;

    // Decode SPI activity on the falling sys_clk edge and drive miso.
    always @(negedge sys_clk) begin
        int         r;
        logic [7:0] b;
        if (cs_n && sck)  viol_cnt++;
        if (cs_n && mosi) viol_cnt++;
        if (done)         done_cnt++;
        if (!busy && cs_n) have_frame = 1'b0;
        if (!cs_n) begin
            if (prev_cs) begin
                if (have_frame) gaps.push_back(m_gap);
                m_nbits = 0;
                m_w32   = 32'h0;
                m_extra = 0;
                m_low   = 0;
            end
            m_low++;
            if (sck && !prev_sck) begin
                if (m_nbits < 32) m_w32[31 - m_nbits] = mosi;
                else if (mosi)    m_extra++;
                m_nbits++;
            end
        end else begin
            if (!prev_cs) begin
                fr_nbits.push_back(m_nbits);
                fr_w32.push_back(m_w32);
                fr_low.push_back(m_low);
                fr_extra.push_back(m_extra);
                have_frame = 1'b1;
                m_gap      = 0;
            end
            m_gap++;
        end
        if (cs_n) begin
            miso = 1'b0;
        end else begin
            r = m_nbits / 8 - 1;
            if (r < 0) begin
                miso = 1'b0;
            end else begin
                b    = (r < wip_cnt) ? wip_val : fin_val;
                miso = b[7 - (m_nbits % 8)];
            end
        end
        prev_cs  = cs_n;
        prev_sck = sck;
    end

    typedef struct packed {
        logic [1:0]       op;
        logic [23:0]      addr;
        logic [15:0]      wip_cnt;
        logic [7:0]       wip_val;
        logic [7:0]       fin_val;
        logic [1:0]       n_frames;
        logic [2:0][7:0]  nb;
        logic [2:0][31:0] w;
        logic [7:0]       exp_status;
        logic             exp_timeout;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(input logic [1:0] op, input logic [23:0] addr,
                                input int wcnt, input logic [7:0] wval, input logic [7:0] fval,
                                input int nf,
                                input int nb0, input logic [31:0] w0,
                                input int nb1, input logic [31:0] w1,
                                input int nb2, input logic [31:0] w2,
                                input logic [7:0] st, input logic to);
        vec_t v;
        v.op          = op;
        v.addr        = addr;
        v.wip_cnt     = 16'(wcnt);
        v.wip_val     = wval;
        v.fin_val     = fval;
        v.n_frames    = 2'(nf);
        v.nb[0]       = 8'(nb0);
        v.nb[1]       = 8'(nb1);
        v.nb[2]       = 8'(nb2);
        v.w[0]        = w0;
        v.w[1]        = w1;
        v.w[2]        = w2;
        v.exp_status  = st;
        v.exp_timeout = to;
        return v;
    endfunction

    // Issue one request, wait for completion and compare every observed
    // transaction against the vector's expectations.
    task automatic apply_vec(input int i);
        vec_t v;
        int   fb, gb, dc, cyc, nf, nb;
        v       = vecs[i];
        nf      = int'(v.n_frames);
        wip_cnt = int'(v.wip_cnt);
        wip_val = v.wip_val;
        fin_val = v.fin_val;
        cyc = 0;
        while (!req_ready && cyc < 100) begin
            @(negedge sys_clk);
            cyc++;
        end
        fb = fr_nbits.size();
        gb = gaps.size();
        dc = done_cnt;
        req_op    = v.op;
        req_addr  = v.addr;
        req_valid = 1'b1;
        @(posedge sys_clk);
        #1 req_valid = 1'b0;
        @(negedge sys_clk);
        check($sformatf("v%0d_ready_after_accept", i), req_ready, 1'b0);
        check($sformatf("v%0d_busy_after_accept", i), busy, 1'b1);
        check($sformatf("v%0d_timeout_cleared", i), timeout, 1'b0);
        cyc = 0;
        while (!done && cyc < 5000) begin
            @(negedge sys_clk);
            cyc++;
        end
        check($sformatf("v%0d_done_seen", i), done, 1'b1);
        check($sformatf("v%0d_busy_at_done", i), busy, 1'b1);
        @(negedge sys_clk);
        check($sformatf("v%0d_ready_after_done", i), req_ready, 1'b1);
        check($sformatf("v%0d_busy_after_done", i), busy, 1'b0);
        repeat (4) @(negedge sys_clk);
        check($sformatf("v%0d_done_pulses", i), done_cnt - dc, 1);
        check($sformatf("v%0d_frames", i), fr_nbits.size() - fb, nf);
        for (int f = 0; f < nf && fb + f < fr_nbits.size(); f++) begin
            nb = int'(v.nb[f]);
            check($sformatf("v%0d_f%0d_bits", i, f), fr_nbits[fb + f], nb);
            check($sformatf("v%0d_f%0d_mosi", i, f), fr_w32[fb + f], v.w[f]);
            check($sformatf("v%0d_f%0d_mosi_tail", i, f), fr_extra[fb + f], 0);
            check($sformatf("v%0d_f%0d_cs_low", i, f), fr_low[fb + f], SCK_DIV * (2 * nb + 1));
        end
        check($sformatf("v%0d_gap_count", i), gaps.size() - gb, nf - 1);
        for (int g = gb; g < gaps.size(); g++) begin
            check($sformatf("v%0d_gap%0d_len", i, g - gb), gaps[g], CS_GAP);
        end
        check($sformatf("v%0d_status", i), status, v.exp_status);
        check($sformatf("v%0d_timeout", i), timeout, v.exp_timeout);
    endtask

    initial begin
        int bad, cyc, fb;

        vecs[0] = mk(2'd3, 24'h000000, 0, 8'h00, 8'h00, 1,
                     8, 32'h06000000, 0, 32'h0, 0, 32'h0, 8'h00, 1'b0);
        vecs[1] = mk(2'd1, 24'h0A1000, 3, 8'h03, 8'h00, 3,
                     8, 32'h06000000, 32, 32'hD80A1000, 40, 32'h05000000, 8'h00, 1'b0);
        vecs[2] = mk(2'd0, 24'h000000, 1000, 8'h03, 8'h00, 3,
                     8, 32'h06000000, 8, 32'hC7000000, 72, 32'h05000000, 8'h03, 1'b1);
        vecs[3] = mk(2'd2, 24'h123456, 0, 8'h00, 8'h1C, 1,
                     16, 32'h05000000, 0, 32'h0, 0, 32'h0, 8'h1C, 1'b0);
        vecs[4] = mk(2'd2, 24'h000000, 5, 8'h01, 8'h00, 1,
                     16, 32'h05000000, 0, 32'h0, 0, 32'h0, 8'h01, 1'b0);
        vecs[5] = mk(2'd0, 24'hABCDEF, 0, 8'h00, 8'h00, 3,
                     8, 32'h06000000, 8, 32'hC7000000, 16, 32'h05000000, 8'h00, 1'b0);
        vecs[6] = mk(2'd1, 24'hFFFFFF, 6, 8'h01, 8'h02, 3,
                     8, 32'h06000000, 32, 32'hD8FFFFFF, 64, 32'h05000000, 8'h02, 1'b0);

        // Reset values while reset is held
        #2 sys_rst_n = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_cs_n", cs_n, 1'b1);
        check("rst_sck", sck, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_status", status, 8'h00);
        check("rst_timeout", timeout, 1'b0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Idle with no request for 1000 cycles
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge sys_clk);
            if (cs_n !== 1'b1 || sck !== 1'b0 || req_ready !== 1'b1 || status !== 8'h00) bad++;
        end
        check("idle_hold_bad_cycles", bad, 0);

        for (int i = 0; i < 7; i++) apply_vec(i);

        // Asynchronous reset in the middle of the CMD transaction
        wip_cnt = 0;
        fin_val = 8'h00;
        fb = fr_nbits.size();
        @(negedge sys_clk);
        req_op    = 2'd1;
        req_addr  = 24'h0A1000;
        req_valid = 1'b1;
        @(posedge sys_clk);
        #1 req_valid = 1'b0;
        cyc = 0;
        while ((fr_nbits.size() < fb + 1 || cs_n) && cyc < 500) begin
            @(negedge sys_clk);
            cyc++;
        end
        check("mid_rst_reached_cmd", (cyc < 500), 1'b1);
        repeat (10) @(negedge sys_clk);
        cyc = 0;
        while (!sck && cyc < 20) begin
            @(negedge sys_clk);
            cyc++;
        end
        check("mid_rst_sck_high_before", sck, 1'b1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("mid_rst_cs_n_async", cs_n, 1'b1);
        check("mid_rst_sck_async", sck, 1'b0);
        check("mid_rst_ready_async", req_ready, 1'b1);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        check("post_rst_ready", req_ready, 1'b1);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_cs_n", cs_n, 1'b1);
        apply_vec(0);

        check("cs_high_sck_or_mosi_active", viol_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
